// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver for the machine's `debug` line.
// Decodes LSB-first frames into bytes with a one-cycle valid strobe.
//
// Optional feature macro: UART_RX_PARITY_EN
//   When defined, frames are 8E1 and a parity_err strobe output is added.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (4..65535)
//   CNT_W         bit-timing counter width (2^CNT_W > CLKS_PER_BIT)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   rx          serial input, idle high, asynchronous
//   data        last good byte, held until the next good byte
//   valid       one-cycle strobe, data valid this cycle
//   frame_err   one-cycle strobe, stop bit sampled low
//   parity_err  one-cycle strobe, even parity failed (UART_RX_PARITY_EN only)
//   busy        high while a frame is in progress
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       data_n;
  logic             valid_n, frame_err_n;
  // Cleared by a low stop sample; IDLE ignores a low line until it has
  // been seen high again, so a held break produces only one frame_err.
  logic             armed, armed_n;
  logic             rx_m, rx_s;
`ifdef UART_RX_PARITY_EN
  logic             par_bit, par_bit_n;
  logic             parity_err_n;
  logic             parity_bad;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      armed     <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift     <= shift_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= frame_err_n;
      armed     <= armed_n;
`ifdef UART_RX_PARITY_EN
      par_bit    <= par_bit_n;
      parity_err <= parity_err_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bit_idx_n   = bit_idx;
    shift_n     = shift;
    data_n      = data;
    valid_n     = 1'b0;
    frame_err_n = 1'b0;
    armed_n     = armed;
`ifdef UART_RX_PARITY_EN
    par_bit_n    = par_bit;
    parity_err_n = 1'b0;
    parity_bad   = ^{shift, par_bit};
`endif
    case (state)
      IDLE: begin
        if (rx_s) begin
          armed_n = 1'b1;
        end else if (armed) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          if (!rx_s) begin
            state_n   = DATA;
            cnt_n     = '0;
            bit_idx_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_M1) begin
          cnt_n            = '0;
          shift_n[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_M1) begin
          cnt_n     = '0;
          par_bit_n = rx_s;
          state_n   = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt == BIT_M1) begin
          // Leaving at mid-stop-bit lets an immediately following start
          // bit be caught without losing cycles.
          state_n = IDLE;
`ifdef UART_RX_PARITY_EN
          parity_err_n = parity_bad;
          if (rx_s) begin
            if (!parity_bad) begin
              data_n  = shift;
              valid_n = 1'b1;
            end
          end else begin
            frame_err_n = 1'b1;
            armed_n     = 1'b0;
          end
`else
          if (rx_s) begin
            data_n  = shift;
            valid_n = 1'b1;
          end else begin
            frame_err_n = 1'b1;
            armed_n     = 1'b0;
          end
`endif
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
